// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC and fetches one word at a time over a req/ready handshake.
// Optional FETCH_TIMEOUT_EN adds a REQ watchdog, a sticky FAULT state and the fetch_fault port.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instr_valid
`ifdef FETCH_TIMEOUT_EN
    , output logic      fetch_fault
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2
`ifdef FETCH_TIMEOUT_EN
        , FAULT = 2'd3
`endif
    } state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] pc_reg;
    logic [31:0] instruction_reg;
    logic        instr_valid_reg;
    logic [31:0] fetch_pc_next;
    logic [31:0] target_aligned;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] count_reg;
    logic             fetch_fault_reg;
`endif

    // Redirects drop the low bits so fetch_pc stays word-aligned; +4 wraps naturally.
    assign target_aligned = branch_target & 32'hFFFF_FFFC;
    assign fetch_pc_next  = fetch_pc_reg + 32'd4;

    assign mem_read    = (state_reg == REQ);
    assign mem_addr    = fetch_pc_reg;
    assign instruction = instruction_reg;
    assign pc          = pc_reg;
    assign instr_valid = instr_valid_reg;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_fault = fetch_fault_reg;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg       <= IDLE;
            fetch_pc_reg    <= RESET_PC;
            pc_reg          <= RESET_PC;
            instruction_reg <= NOP;
            instr_valid_reg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            count_reg       <= '0;
            fetch_fault_reg <= 1'b0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
            if (state_reg == FAULT) begin
                // Sticky until reset; redirects are ignored here.
                state_reg <= FAULT;
            end else
`endif
            if (branch_taken) begin
                fetch_pc_reg    <= target_aligned;
                instr_valid_reg <= 1'b0;
                instruction_reg <= NOP;
                state_reg       <= REQ;
`ifdef FETCH_TIMEOUT_EN
                count_reg       <= '0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        count_reg <= '0;
`endif
                    end
                    REQ: begin
                        if (mem_ready) begin
                            instruction_reg <= mem_rdata;
                            pc_reg          <= fetch_pc_reg;
                            instr_valid_reg <= 1'b1;
                            fetch_pc_reg    <= fetch_pc_next;
                            state_reg       <= HOLD;
`ifdef FETCH_TIMEOUT_EN
                        // The TIMEOUT_CYCLES-th waiting cycle faults unless ready arrives in it.
                        end else if (count_reg == CNT_LAST) begin
                            fetch_fault_reg <= 1'b1;
                            instr_valid_reg <= 1'b0;
                            instruction_reg <= NOP;
                            state_reg       <= FAULT;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
`endif
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            instr_valid_reg <= 1'b0;
                            instruction_reg <= NOP;
                            state_reg       <= REQ;
`ifdef FETCH_TIMEOUT_EN
                            count_reg       <= '0;
`endif
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed corner cases plus a randomized run
// against a transaction-level model of the fetch stream (timeout cases when FETCH_TIMEOUT_EN).
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_fault;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch dut (
        .clk(clk),
        .nRst(nRst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_read(mem_read),
        .mem_addr(mem_addr),
        .instruction(instruction),
        .pc(pc),
        .instr_valid(instr_valid)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        mem_ready = 1'b0; mem_rdata = $urandom;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b, expected 0", mem_read); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 00000000", mem_addr); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 00000000", pc); end
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL reset_instruction: got %h, expected %h", instruction, NOP); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", instr_valid); end
`ifdef FETCH_TIMEOUT_EN
        n_tests++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b, expected 0", fetch_fault); end
`endif
        nRst = 1'b1;
        @(negedge clk);
        n_tests++; if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got read=%b addr=%h, expected read=1 addr=00000000", mem_read, mem_addr); end
    endtask

    task automatic test_first_fetch();
        mem_ready = 1'b1; mem_rdata = 32'h0020_81B3;
        @(negedge clk);
        clear_inputs();
        $display("[TB] fetch pc=%h instr=%h", pc, instruction);
        n_tests++; if (instruction !== 32'h0020_81B3) begin n_fail++; $display("FAIL first_instr: got %h, expected 002081b3", instruction); end
        n_tests++; if (pc !== 32'h0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL first_pc_valid: got pc=%h v=%b, expected pc=00000000 v=1", pc, instr_valid); end
        n_tests++; if (mem_read !== 1'b0 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL first_next_addr: got read=%b addr=%h, expected read=0 addr=00000004", mem_read, mem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (instruction !== 32'h0020_81B3 || pc !== 32'h0 || instr_valid !== 1'b1 || mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: got instr=%h pc=%h v=%b rd=%b, expected instr=002081b3 pc=00000000 v=1 rd=0", instruction, pc, instr_valid, mem_read);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0 || instruction !== NOP) begin n_fail++; $display("FAIL stall_release: got v=%b instr=%h, expected v=0 instr=%h", instr_valid, instruction, NOP); end
        n_tests++; if (mem_read !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_next_req: got read=%b addr=%h, expected read=1 addr=00000004", mem_read, mem_addr); end
    endtask

    task automatic test_branch_collision();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        @(negedge clk);
        clear_inputs();
        n_tests++; if (instr_valid !== 1'b0 || instruction !== NOP) begin n_fail++; $display("FAIL branch_drop: got v=%b instr=%h, expected v=0 instr=%h", instr_valid, instruction, NOP); end
        n_tests++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL branch_addr: got read=%b addr=%h, expected read=1 addr=00000100", mem_read, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h00A0_0093;
        @(negedge clk);
        clear_inputs();
        $display("[TB] fetch pc=%h instr=%h", pc, instruction);
        n_tests++; if (pc !== 32'h100 || instruction !== 32'h00A0_0093) begin n_fail++; $display("FAIL branch_fetch: got pc=%h instr=%h, expected pc=00000100 instr=00a00093", pc, instruction); end
    endtask

    task automatic test_wrap();
        // Redirect from HOLD while stalled: branch must win over stall.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        clear_inputs();
        n_tests++; if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_redirect: got v=%b rd=%b addr=%h, expected v=0 rd=1 addr=fffffffc", instr_valid, mem_read, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h0000_0073;
        @(negedge clk);
        clear_inputs();
        $display("[TB] fetch pc=%h instr=%h", pc, instruction);
        n_tests++; if (pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch: got pc=%h v=%b addr=%h, expected pc=fffffffc v=1 addr=00000000", pc, instr_valid, mem_addr); end
        @(negedge clk);
        n_tests++; if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_req: got read=%b addr=%h, expected read=1 addr=00000000", mem_read, mem_addr); end
    endtask

    task automatic test_reset_mid();
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        @(negedge clk);
        clear_inputs();
        n_tests++; if (mem_addr !== 32'h200 || mem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got read=%b addr=%h, expected read=1 addr=00000200", mem_read, mem_addr); end
        nRst = 1'b0;
        #1;
        n_tests++; if (mem_read !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got rd=%b addr=%h v=%b, expected rd=0 addr=00000000 v=0", mem_read, mem_addr, instr_valid); end
        @(negedge clk);
        nRst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        mem_ready = 1'b0;
        n_tests++; if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_late_ready: got v=%b rd=%b addr=%h, expected v=0 rd=1 addr=00000000", instr_valid, mem_read, mem_addr); end
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0 || mem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_waiting: got v=%b rd=%b, expected v=0 rd=1", instr_valid, mem_read); end
    endtask

    // Model tracks only the fetch stream: which address is owed next and which word is held.
    task automatic test_random();
        bit          started = 0;
        bit          have_word = 0;
        logic [31:0] next_addr = 32'h0;
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] exp_instr = NOP;
        int          wait_cnt = 0;
        bit          requesting;
        nRst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            requesting = started && !have_word;
            n_tests++; if (mem_read !== requesting) begin n_fail++; $display("FAIL rnd_mem_read cyc=%0d: got %b, expected %b", cyc, mem_read, requesting); end
            n_tests++; if (mem_addr !== next_addr) begin n_fail++; $display("FAIL rnd_mem_addr cyc=%0d: got %h, expected %h", cyc, mem_addr, next_addr); end
            n_tests++; if (instr_valid !== have_word) begin n_fail++; $display("FAIL rnd_valid cyc=%0d: got %b, expected %b", cyc, instr_valid, have_word); end
            n_tests++; if (instruction !== (have_word ? exp_instr : NOP)) begin n_fail++; $display("FAIL rnd_instr cyc=%0d: got %h, expected %h", cyc, instruction, have_word ? exp_instr : NOP); end
            if (have_word) begin
                n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d: got %h, expected %h", cyc, pc, exp_pc); end
            end
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            stall         = ($urandom_range(0, 1) == 1);
            if (requesting) mem_ready = ($urandom_range(0, 9) < 6) || (wait_cnt >= 8);
            else            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = (requesting && mem_ready) ? mem_word(next_addr) : $urandom;
            if (branch_taken) begin
                have_word = 0; next_addr = branch_target & 32'hFFFF_FFFC; started = 1; wait_cnt = 0;
            end else if (!started) begin
                started = 1;
            end else if (requesting && mem_ready) begin
                have_word = 1; exp_pc = next_addr; exp_instr = mem_rdata; next_addr = next_addr + 32'd4; wait_cnt = 0;
                $display("[TB] fetch pc=%h instr=%h", exp_pc, exp_instr);
            end else if (requesting) begin
                wait_cnt++;
            end else if (have_word && !stall) begin
                have_word = 0;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        nRst = 1'b0;
        clear_inputs();
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        repeat (15) @(negedge clk);
        n_tests++; if (mem_read !== 1'b1 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL tmo_before: got rd=%b fault=%b, expected rd=1 fault=0", mem_read, fetch_fault); end
        @(negedge clk);
        n_tests++; if (fetch_fault !== 1'b1 || mem_read !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP) begin n_fail++; $display("FAIL tmo_fault: got fault=%b rd=%b v=%b instr=%h, expected fault=1 rd=0 v=0 instr=%h", fetch_fault, mem_read, instr_valid, instruction, NOP); end
        branch_taken = 1'b1; branch_target = 32'h0000_0040;
        @(negedge clk);
        clear_inputs();
        n_tests++; if (fetch_fault !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL tmo_branch_ignored: got fault=%b rd=%b addr=%h, expected fault=1 rd=0 addr=00000000", fetch_fault, mem_read, mem_addr); end
        nRst = 1'b0;
        @(negedge clk);
        n_tests++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_clear: got %b, expected 0", fetch_fault); end
        nRst = 1'b1;
        @(negedge clk);
        repeat (15) @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5013;
        @(negedge clk);
        clear_inputs();
        n_tests++; if (fetch_fault !== 1'b0 || instr_valid !== 1'b1 || instruction !== 32'h1234_5013) begin n_fail++; $display("FAIL tmo_ready_wins: got fault=%b v=%b instr=%h, expected fault=0 v=1 instr=12345013", fetch_fault, instr_valid, instruction); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_collision();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
